// File: rtl/seg_scroll_engine.sv
// seg_scroll_engine
// Marquee engine for multi-digit 7-segment displays. A message held in a small
// glyph buffer scrolls in at the top digit and leaves at digit 0, one frame per
// prescaler wrap. Supports one-shot or looping playback, level pause and abort.
module seg_scroll_engine #(
    parameter int  N_DIG   = 4,
    parameter int  MSG_MAX = 16,
    parameter int  DIVISOR = 9000000,
    localparam int AW      = $clog2(MSG_MAX),
    localparam int LW      = $clog2(MSG_MAX + 1),
    localparam int PW      = $clog2(MSG_MAX + N_DIG + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               msg_we,
    input  logic [AW-1:0]      msg_waddr,
    input  logic [6:0]         msg_wdata,
    input  logic [LW-1:0]      msg_len,
    input  logic               loop,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    output logic               busy,
    output logic               done,
    output logic [PW-1:0]      frame,
    output logic [N_DIG*7-1:0] display
);

    // Prescaler width; DIVISOR is at least 2 so this is never zero.
    localparam int DW = $clog2(DIVISOR);

    typedef enum logic {
        IDLE,
        SCROLL
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      frame_q, frame_d;
    logic [DW-1:0]      pre_q, pre_d;
    logic [LW-1:0]      len_q, len_d;
    logic               load_q, load_d;
    logic               done_q, done_d;
    logic [N_DIG*7-1:0] disp_q, disp_d;

    logic [6:0]         glyph_q [MSG_MAX];

    logic [LW-1:0]      lenClamp;
    logic [PW-1:0]      lastFrame;
    logic               tick;

    // Requested length saturates at the buffer depth.
    assign lenClamp  = (msg_len > LW'(MSG_MAX)) ? LW'(MSG_MAX) : msg_len;

    // The final frame (index len + N_DIG - 1) is always fully blank.
    assign lastFrame = PW'(len_q) + PW'(N_DIG - 1);

    // A tick only happens while scrolling and not frozen by pause.
    assign tick      = (state_q == SCROLL) && !pause && (pre_q == DW'(DIVISOR - 1));

    assign busy      = (state_q == SCROLL);
    assign done      = done_q;
    assign frame     = frame_q;
    assign display   = disp_q;

    // Builds the digit pattern for frame k. Digit j looks back (N_DIG-1-j)
    // glyphs from k; the signed index turns "not yet entered" into blank.
    function automatic logic [N_DIG*7-1:0] frameContent(input logic [PW-1:0] k);
        logic [N_DIG*7-1:0] r;
        logic signed [PW:0] idx;
        r = '0;
        for (int j = 0; j < N_DIG; j++) begin
            idx = $signed({1'b0, k}) - $signed((PW+1)'(N_DIG - 1 - j));
            if (!idx[PW] && (idx[PW-1:0] < PW'(len_q))) begin
                r[7*j +: 7] = glyph_q[idx[AW-1:0]];
            end
        end
        return r;
    endfunction

    // Glyph buffer: plain synchronous write port, no reset, writable any time.
    always_ff @(posedge clk) begin
        if (msg_we && (32'(msg_waddr) < MSG_MAX)) begin
            glyph_q[msg_waddr] <= msg_wdata;
        end
    end

    // Next-state logic: stop beats start, start beats tick.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        pre_d   = pre_q;
        len_d   = len_q;
        load_d  = 1'b0;
        done_d  = 1'b0;
        disp_d  = disp_q;

        if (stop) begin
            state_d = IDLE;
            frame_d = '0;
            pre_d   = '0;
            disp_d  = '0;
        end else if (start && (lenClamp != '0)) begin
            len_d   = lenClamp;
            state_d = SCROLL;
            frame_d = '0;
            pre_d   = '0;
            load_d  = 1'b1;
        end else if (state_q == SCROLL) begin
            if (load_q) begin
                disp_d = frameContent(frame_q);
            end
            if (!pause) begin
                if (tick) begin
                    pre_d = '0;
                    if (frame_q == lastFrame) begin
                        if (loop) begin
                            frame_d = '0;
                            disp_d  = frameContent('0);
                        end else begin
                            state_d = IDLE;
                            frame_d = '0;
                            done_d  = 1'b1;
                            disp_d  = '0;
                        end
                    end else begin
                        frame_d = frame_q + PW'(1);
                        disp_d  = frameContent(frame_q + PW'(1));
                    end
                end else begin
                    pre_d = pre_q + DW'(1);
                end
            end
        end
    end

    // State, counters and the registered display image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            frame_q <= '0;
            pre_q   <= '0;
            len_q   <= '0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            pre_q   <= pre_d;
            len_q   <= len_d;
            load_q  <= load_d;
            done_q  <= done_d;
            disp_q  <= disp_d;
        end
    end

endmodule

// File: tb/tb_seg_scroll_engine.sv
// tb_seg_scroll_engine
// Directed bench for the scroll engine with a small glyph model and a queue of
// expected frames that is drained at each frame boundary.
module tb_seg_scroll_engine;

    localparam int N_DIG   = 4;
    localparam int MSG_MAX = 16;
    localparam int DIVISOR = 4;
    localparam int AW      = 4;
    localparam int LW      = 5;
    localparam int PW      = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              msg_we = 1'b0;
    logic [AW-1:0]     msg_waddr = '0;
    logic [6:0]        msg_wdata = '0;
    logic [LW-1:0]     msg_len = '0;
    logic              loop = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              pause = 1'b0;
    logic              busy;
    logic              done;
    logic [PW-1:0]     frame;
    logic [N_DIG*7-1:0] display;

    typedef struct {
        int          frameIdx;
        logic [27:0] disp;
    } expEntry_t;

    expEntry_t   scoreQ[$];
    logic [6:0]  tbGlyph [MSG_MAX];
    int          checks = 0;
    int          failures = 0;

    seg_scroll_engine #(
        .N_DIG   (N_DIG),
        .MSG_MAX (MSG_MAX),
        .DIVISOR (DIVISOR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .msg_we    (msg_we),
        .msg_waddr (msg_waddr),
        .msg_wdata (msg_wdata),
        .msg_len   (msg_len),
        .loop      (loop),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .busy      (busy),
        .done      (done),
        .frame     (frame),
        .display   (display)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Reference image of frame k for a message of the given length.
    function automatic logic [27:0] modelFrame(input int k, input int len);
        logic [27:0] r;
        r = '0;
        for (int j = 0; j < N_DIG; j++) begin
            int idx;
            idx = k - (N_DIG - 1 - j);
            if (idx >= 0 && idx < len) r[7*j +: 7] = tbGlyph[idx];
        end
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic writeGlyph(input int addr, input logic [6:0] data);
        msg_waddr = AW'(addr);
        msg_wdata = data;
        msg_we    = 1'b1;
        tick(1);
        msg_we    = 1'b0;
        tbGlyph[addr] = data;
    endtask

    task automatic applyStimulus(input logic startV, input logic stopV, input int lenV, input logic loopV);
        msg_len = LW'(lenV);
        loop    = loopV;
        start   = startV;
        stop    = stopV;
        tick(1);
        start   = 1'b0;
        stop    = 1'b0;
    endtask

    task automatic pushFrames(input int first, input int last, input int len);
        for (int k = first; k <= last; k++) begin
            expEntry_t e;
            e.frameIdx = k;
            e.disp     = modelFrame(k, len);
            scoreQ.push_back(e);
        end
    endtask

    task automatic popCheck();
        expEntry_t e;
        if (scoreQ.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = scoreQ.pop_front();
            checkOutput($sformatf("frame%0d.index", e.frameIdx), 32'(frame), 32'(e.frameIdx));
            checkOutput($sformatf("frame%0d.display", e.frameIdx), 32'(display), 32'(e.disp));
            checkOutput($sformatf("frame%0d.busy", e.frameIdx), 32'(busy), 32'd1);
            checkOutput($sformatf("frame%0d.done", e.frameIdx), 32'(done), 32'd0);
        end
    endtask

    task automatic nextFrame(input int gap);
        tick(gap);
        popCheck();
    endtask

    // Frame 0 shows one edge after start acceptance, frame 1 three edges later,
    // then one frame every DIVISOR edges.
    task automatic followScroll(input int n);
        for (int i = 0; i < n; i++) begin
            if (i == 0) nextFrame(1);
            else if (i == 1) nextFrame(DIVISOR - 1);
            else nextFrame(DIVISOR);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".display"}, 32'(display), 32'd0);
        checkOutput({tag, ".frame"}, 32'(frame), 32'd0);
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        $display("[TB] reset");
        tick(2);
        checkIdle("reset");
        checkOutput("reset.done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick(1);

        writeGlyph(0, 7'd118);
        writeGlyph(1, 7'd63);
        writeGlyph(2, 7'd56);
        writeGlyph(3, 7'd119);
        for (int i = 4; i < MSG_MAX; i++) writeGlyph(i, 7'(i * 9 + 3));

        $display("[TB] one-shot HOLA");
        applyStimulus(1'b1, 1'b0, 4, 1'b0);
        checkOutput("t1.busyAfterStart", 32'(busy), 32'd1);
        checkOutput("t1.displayLatency", 32'(display), 32'd0);
        pushFrames(0, 7, 4);
        nextFrame(1);
        checkOutput("t1.frame0Literal", 32'(display), {4'd0, 7'd118, 21'd0});
        nextFrame(3);
        nextFrame(4);
        nextFrame(4);
        checkOutput("t1.frame3Literal", 32'(display), {4'd0, 7'd119, 7'd56, 7'd63, 7'd118});
        for (int i = 4; i < 8; i++) nextFrame(4);
        tick(4);
        checkOutput("t1.donePulse", 32'(done), 32'd1);
        checkIdle("t1.end");
        tick(1);
        checkOutput("t1.doneFalls", 32'(done), 32'd0);

        $display("[TB] looping HOLA");
        applyStimulus(1'b1, 1'b0, 4, 1'b1);
        pushFrames(0, 7, 4);
        pushFrames(0, 0, 4);
        followScroll(9);
        checkOutput("t2.wrapLiteral", 32'(display), {4'd0, 7'd118, 21'd0});
        applyStimulus(1'b0, 1'b1, 4, 1'b0);
        checkIdle("t2.stop");
        checkOutput("t2.stopNoDone", 32'(done), 32'd0);

        $display("[TB] length boundaries");
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
        checkIdle("t3.zeroLen");
        tick(DIVISOR);
        checkIdle("t3.zeroLenLater");
        applyStimulus(1'b1, 1'b0, 20, 1'b0);
        pushFrames(0, 19, 16);
        followScroll(20);
        tick(DIVISOR);
        checkOutput("t3.clampDone", 32'(done), 32'd1);
        checkIdle("t3.clampEnd");

        $display("[TB] pause");
        applyStimulus(1'b1, 1'b0, 4, 1'b0);
        pushFrames(0, 2, 4);
        followScroll(3);
        tick(2);
        pause = 1'b1;
        tick(10);
        checkOutput("t4.pausedFrame", 32'(frame), 32'd2);
        checkOutput("t4.pausedDisplay", 32'(display), 32'(modelFrame(2, 4)));
        checkOutput("t4.pausedBusy", 32'(busy), 32'd1);
        pause = 1'b0;
        tick(1);
        checkOutput("t4.remainingCount", 32'(frame), 32'd2);
        tick(1);
        checkOutput("t4.resumeFrame", 32'(frame), 32'd3);
        checkOutput("t4.resumeDisplay", 32'(display), 32'(modelFrame(3, 4)));
        applyStimulus(1'b0, 1'b1, 4, 1'b0);
        checkIdle("t4.stop");

        $display("[TB] start with stop");
        applyStimulus(1'b1, 1'b0, 4, 1'b0);
        pushFrames(0, 3, 4);
        followScroll(4);
        applyStimulus(1'b1, 1'b1, 4, 1'b0);
        checkIdle("t5.stopWins");
        checkOutput("t5.noDone", 32'(done), 32'd0);
        applyStimulus(1'b1, 1'b0, 4, 1'b0);
        checkOutput("t5.restartBusy", 32'(busy), 32'd1);
        checkOutput("t5.restartFrame", 32'(frame), 32'd0);
        pushFrames(0, 1, 4);
        followScroll(2);
        applyStimulus(1'b0, 1'b1, 4, 1'b0);
        checkIdle("t5.stop");

        $display("[TB] async reset");
        applyStimulus(1'b1, 1'b0, 4, 1'b0);
        pushFrames(0, 2, 4);
        followScroll(3);
        #3;
        rst_n = 1'b0;
        #1;
        checkIdle("t6.asyncReset");
        checkOutput("t6.asyncResetDone", 32'(done), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        applyStimulus(1'b1, 1'b0, 4, 1'b0);
        pushFrames(0, 7, 4);
        followScroll(8);
        tick(DIVISOR);
        checkOutput("t6.donePulse", 32'(done), 32'd1);
        checkIdle("t6.end");

        checkOutput("scoreboardDrained", 32'(scoreQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
